// File: rtl/collision_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : collision_scheduler
//  Description : Round-robin time-sharing of one collision engine between
//                N_REQ life slots. Grants a slot, latches its coordinate and
//                size, pulses the engine start, waits for the result (with a
//                timeout) and returns the collision vector with a one-hot ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module collision_scheduler #(
  parameter int N_REQ   = 10,
  parameter int CW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [CW*N_REQ-1:0] self_coord,
  input  logic [CW*N_REQ-1:0] self_size,
  output logic                eng_start,
  output logic [CW-1:0]       eng_coord,
  output logic [CW-1:0]       eng_size,
  input  logic                eng_done,
  input  logic [3:0]          eng_collision,
  output logic [N_REQ-1:0]    ack,
  output logic [3:0]          rsp_collision,
  output logic [3:0]          rsp_id,
  output logic                rsp_timeout,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] C_TIMEOUT = 4'(TIMEOUT);
  localparam logic [3:0] C_LAST    = 4'(N_REQ - 1);

  state_t        state_q, state_d;
  logic [3:0]    rr_q, rr_d;
  logic [CW-1:0] coord_q, coord_d;
  logic [CW-1:0] size_q, size_d;
  logic [3:0]    id_q, id_d;
  logic [3:0]    col_q, col_d;
  logic          to_q, to_d;
  logic [3:0]    cnt_q, cnt_d;

  logic          w_hi_found;
  logic [3:0]    w_hi_idx;
  logic [3:0]    w_lo_idx;
  logic [3:0]    w_pick;
  logic [CW-1:0] w_sel_coord;
  logic [CW-1:0] w_sel_size;

  // Round-robin pick: lowest requester at or above rr_q, else lowest overall (wrap).
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_idx = 4'(i);
        if (4'(i) >= rr_q) begin
          w_hi_found = 1'b1;
          w_hi_idx   = 4'(i);
        end
      end
    end
    w_pick = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  // Select the picked slot's coordinate and size from the packed buses.
  always_comb begin
    w_sel_coord = '0;
    w_sel_size  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick == 4'(i)) begin
        w_sel_coord = self_coord[i*CW +: CW];
        w_sel_size  = self_size[i*CW +: CW];
      end
    end
  end

  // Next-state logic: grant in IDLE, start in ISSUE, collect or time out in WAIT.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    coord_d = coord_q;
    size_d  = size_q;
    id_d    = id_q;
    col_d   = col_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          coord_d = w_sel_coord;
          size_d  = w_sel_size;
          id_d    = w_pick;
          rr_d    = (w_pick == C_LAST) ? 4'd0 : w_pick + 4'd1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 4'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the final wait cycle still beats the timeout.
        if (eng_done) begin
          col_d   = eng_collision;
          to_d    = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == C_TIMEOUT) begin
          col_d   = 4'd0;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      coord_q <= '0;
      size_q  <= '0;
      id_q    <= '0;
      col_q   <= '0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      coord_q <= coord_d;
      size_q  <= size_d;
      id_q    <= id_d;
      col_q   <= col_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode: start pulse, busy flag and one-hot ack in RESP.
  always_comb begin
    eng_start     = (state_q == S_ISSUE);
    busy          = (state_q != S_IDLE);
    eng_coord     = coord_q;
    eng_size      = size_q;
    rsp_id        = id_q;
    rsp_collision = col_q;
    rsp_timeout   = to_q;
    ack           = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ack[i] = (state_q == S_RESP) && (id_q == 4'(i));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_collision_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_collision_scheduler
//  Description : Self-checking bench for collision_scheduler with a
//                transaction-level reference model of grant order and timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_scheduler;

  localparam int N  = 10;
  localparam int CW = 32;
  localparam int T  = 15;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [CW*N-1:0] self_coord;
  logic [CW*N-1:0] self_size;
  logic            eng_start;
  logic [CW-1:0]   eng_coord;
  logic [CW-1:0]   eng_size;
  logic            eng_done;
  logic [3:0]      eng_collision;
  logic [N-1:0]    ack;
  logic [3:0]      rsp_collision;
  logic [3:0]      rsp_id;
  logic            rsp_timeout;
  logic            busy;

  collision_scheduler #(.N_REQ(N), .CW(CW), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req(req), .self_coord(self_coord), .self_size(self_size),
    .eng_start(eng_start), .eng_coord(eng_coord), .eng_size(eng_size),
    .eng_done(eng_done), .eng_collision(eng_collision), .ack(ack),
    .rsp_collision(rsp_collision), .rsp_id(rsp_id), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending requests, slot data and round-robin pointer.
  logic [N-1:0]  req_v;
  logic [CW-1:0] coord_v [N];
  logic [CW-1:0] size_v  [N];
  int            model_ptr;
  int            grant_cnt [N];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    req = req_v;
    for (int i = 0; i < N; i++) begin
      self_coord[i*CW +: CW] = coord_v[i];
      self_size[i*CW +: CW]  = size_v[i];
    end
  endtask

  function automatic int exp_grant();
    for (int k = 0; k < N; k++) begin
      if (req_v[(model_ptr + k) % N]) return (model_ptr + k) % N;
    end
    return -1;
  endfunction

  // One full transaction; d = cycles from start to eng_done (beyond window = never).
  task automatic do_txn(input int d, input logic [3:0] col, input bit drop_ack,
                        input bit chg_after, output int g_obs);
    int g;
    int waited;
    int ack_at;
    bit timed;
    logic [CW-1:0] ec;
    logic [CW-1:0] es;
    logic [N-1:0]  exp_ack;
    g      = exp_grant();
    g_obs  = -1;
    ec     = coord_v[g];
    es     = size_v[g];
    waited = 0;
    while (eng_start !== 1'b1 && waited < 8) begin
      step();
      waited++;
    end
    n_checks++;
    if (eng_start !== 1'b1) begin
      $display("FAIL start_wait: eng_start=%b expected 1 within 8 cycles", eng_start);
      n_errors++;
      return;
    end
    model_ptr = (g + 1) % N;
    n_checks++;
    if (rsp_id !== 4'(g)) begin
      $display("FAIL grant_id: got %0d expected %0d", rsp_id, g);
      n_errors++;
    end
    n_checks++;
    if (eng_coord !== ec || eng_size !== es) begin
      $display("FAIL grant_data: coord %h size %h expected %h %h", eng_coord, eng_size, ec, es);
      n_errors++;
    end
    n_checks++;
    if (busy !== 1'b1) begin
      $display("FAIL busy_issue: got %b expected 1", busy);
      n_errors++;
    end
    if (chg_after) begin
      req_v[g]   = 1'b0;
      coord_v[g] = $urandom;
      size_v[g]  = $urandom;
      apply();
    end
    timed  = (d > T + 1);
    ack_at = timed ? T + 2 : d + 1;
    exp_ack = '0;
    exp_ack[g] = 1'b1;
    for (int k = 1; k <= ack_at; k++) begin
      step();
      n_checks++;
      if (eng_start !== 1'b0 || eng_coord !== ec || eng_size !== es) begin
        $display("FAIL hold_k%0d: start %b coord %h size %h expected 0 %h %h",
                 k, eng_start, eng_coord, eng_size, ec, es);
        n_errors++;
      end
      if (k < ack_at) begin
        n_checks++;
        if (ack !== '0) begin
          $display("FAIL early_ack_k%0d: got %b expected 0", k, ack);
          n_errors++;
        end
      end else begin
        g_obs = int'(rsp_id);
        n_checks++;
        if (ack !== exp_ack) begin
          $display("FAIL ack: got %b expected %b", ack, exp_ack);
          n_errors++;
        end
        n_checks++;
        if (rsp_collision !== (timed ? 4'd0 : col) || rsp_timeout !== timed) begin
          $display("FAIL rsp: collision %b timeout %b expected %b %b",
                   rsp_collision, rsp_timeout, timed ? 4'd0 : col, timed);
          n_errors++;
        end
      end
      eng_done      = (k == d) && (k < ack_at);
      eng_collision = (k == d) ? col : 4'($urandom_range(0, 15));
    end
    eng_done = 1'b0;
    if (drop_ack) begin
      req_v[g] = 1'b0;
      apply();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (busy !== 1'b0 || ack !== '0 || eng_start !== 1'b0) begin
      $display("FAIL reset_ctrl: busy %b ack %b start %b expected 0", busy, ack, eng_start);
      n_errors++;
    end
    n_checks++;
    if (eng_coord !== '0 || eng_size !== '0 || rsp_id !== 4'd0 ||
        rsp_collision !== 4'd0 || rsp_timeout !== 1'b0) begin
      $display("FAIL reset_data: coord %h size %h id %0d col %b to %b expected 0",
               eng_coord, eng_size, rsp_id, rsp_collision, rsp_timeout);
      n_errors++;
    end
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_round_robin();
    int g;
    for (int i = 0; i < N; i++) begin
      grant_cnt[i] = 0;
      coord_v[i]   = $urandom;
      size_v[i]    = $urandom;
    end
    req_v = '1;
    apply();
    for (int t = 0; t < N + 1; t++) begin
      do_txn(1, 4'($urandom_range(0, 15)), 1'b0, 1'b0, g);
      n_checks++;
      if (g != t % N) begin
        $display("FAIL rr_order_t%0d: got %0d expected %0d", t, g, t % N);
        n_errors++;
      end
      if (t < N && g >= 0 && g < N) grant_cnt[g]++;
    end
    req_v = '0;
    apply();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (grant_cnt[i] != 1) begin
        $display("FAIL rr_count_%0d: got %0d expected 1", i, grant_cnt[i]);
        n_errors++;
      end
    end
  endtask

  task automatic test_single();
    int g;
    coord_v[3] = {16'd370, 16'd400};
    size_v[3]  = {16'd16, 16'd32};
    req_v      = 10'b00_0000_1000;
    apply();
    do_txn(2, 4'b0100, 1'b1, 1'b0, g);
  endtask

  task automatic test_timeout();
    int g;
    req_v = 10'b00_0010_0000;
    apply();
    do_txn(100, 4'b1111, 1'b1, 1'b0, g);
    step();
    for (int k = 0; k < 4; k++) begin
      eng_done      = (k < 3);
      eng_collision = 4'b1111;
      step();
      n_checks++;
      if (ack !== '0 || busy !== 1'b0) begin
        $display("FAIL stray_done_k%0d: ack %b busy %b expected 0 0", k, ack, busy);
        n_errors++;
      end
    end
    eng_done = 1'b0;
  endtask

  task automatic test_done_at_timeout();
    int g;
    req_v = 10'b00_0000_0010;
    apply();
    do_txn(T + 1, 4'b1000, 1'b1, 1'b0, g);
  endtask

  task automatic test_reset_mid();
    int g;
    int waited;
    coord_v[2] = $urandom;
    coord_v[7] = $urandom;
    req_v = 10'b00_0000_0100;
    apply();
    waited = 0;
    while (eng_start !== 1'b1 && waited < 8) begin
      step();
      waited++;
    end
    step();
    step();
    req_v[7] = 1'b1;
    apply();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_ptr = 0;
    n_checks++;
    if (busy !== 1'b0 || ack !== '0) begin
      $display("FAIL abort: busy %b ack %b expected 0 0", busy, ack);
      n_errors++;
    end
    do_txn(1, 4'b0011, 1'b1, 1'b0, g);
    do_txn(3, 4'b0101, 1'b1, 1'b0, g);
  endtask

  task automatic test_drop_after_grant();
    int g;
    coord_v[4] = {16'd100, 16'd200};
    size_v[4]  = {16'd8, 16'd8};
    req_v = 10'b00_0001_0000;
    apply();
    do_txn(4, 4'b0110, 1'b1, 1'b1, g);
  endtask

  task automatic test_random();
    int g;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] && $urandom_range(0, 2) == 0) begin
          req_v[i]   = 1'b1;
          coord_v[i] = $urandom;
          size_v[i]  = $urandom;
        end
      end
      if (req_v == '0) req_v[$urandom_range(0, N - 1)] = 1'b1;
      apply();
      do_txn($urandom_range(1, 20), 4'($urandom_range(0, 15)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, g);
    end
    req_v = '0;
    apply();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    eng_done      = 1'b0;
    eng_collision = 4'd0;
    req_v         = '0;
    model_ptr     = 0;
    for (int i = 0; i < N; i++) begin
      coord_v[i] = '0;
      size_v[i]  = '0;
    end
    apply();
    test_reset();
    test_round_robin();
    test_single();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid();
    test_drop_after_grant();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
